// File: rtl/enet_pll_supervisor.sv
// rtl/enet_pll_supervisor.sv - Ethernet PLL lock supervisor and reset sequencer
// Drives pll_areset, qualifies pll_locked, retries on timeout and exposes an Avalon-MM register file.
module enet_pll_supervisor #(
  parameter int RESET_CYCLES = 64,
  parameter int LOCK_FILTER  = 16,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int MAX_RETRIES  = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  input  logic        pll_locked,
  output logic        pll_areset,
  output logic        resetrequest,
  output logic        irq
);

  localparam int RCW = $clog2(RESET_CYCLES + 1);
  localparam int FW  = $clog2(LOCK_FILTER + 1);
  localparam int TW  = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [RCW-1:0] RST_LAST  = RCW'(RESET_CYCLES - 1);
  localparam logic [FW-1:0]  FILT_LAST = FW'(LOCK_FILTER - 1);
  localparam logic [TW-1:0]  TMO_LAST  = TW'(LOCK_TIMEOUT - 1);
  localparam logic [2:0]     RETRY_MAX = 3'(MAX_RETRIES);

  typedef enum logic [1:0] {
    ST_ASSERT_RST = 2'd0,
    ST_WAIT_LOCK  = 2'd1,
    ST_LOCKED     = 2'd2,
    ST_FAULT      = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_lk_meta;
  logic             r_lk_s;
  logic [RCW-1:0]   r_rst_cnt;
  logic [FW-1:0]    r_filt;
  logic [TW-1:0]    r_tmo;
  logic [2:0]       r_retry;
  logic             r_pll_areset;
  logic             r_resetrequest;
  logic             r_irq;
  logic             r_auto_relock;
  logic [1:0]       r_irq_mask;
  logic [15:0]      r_loss_cnt;
  logic [1:0]       r_irq_status;

  logic             w_wr;
  logic             w_wr_ctrl;
  logic             w_wr_loss;
  logic             w_wr_irq;
  logic             w_force;
  logic             w_lock;
  logic             w_timeout;
  logic             w_loss;
  logic [2:0]       w_retry_inc;
  logic             w_retry_exhausted;
  logic             w_set_fault;
  logic [1:0]       w_irq_clr;
  logic             w_unused;

  assign w_wr      = chipselect & write;
  assign w_wr_ctrl = w_wr && (address == 3'd1);
  assign w_wr_loss = w_wr && (address == 3'd2);
  assign w_wr_irq  = w_wr && (address == 3'd3);
  assign w_force   = w_wr_ctrl && writedata[0];

  // Lock wins over a coincident timeout: the filter has already seen its last good cycle.
  assign w_lock            = (r_state == ST_WAIT_LOCK) && r_lk_s && (r_filt == FILT_LAST);
  assign w_timeout         = (r_state == ST_WAIT_LOCK) && !w_lock && (r_tmo == TMO_LAST);
  assign w_loss            = (r_state == ST_LOCKED) && !r_lk_s;
  assign w_retry_inc       = r_retry + 3'd1;
  assign w_retry_exhausted = (w_retry_inc >= RETRY_MAX);
  assign w_set_fault       = !w_force && ((w_timeout && w_retry_exhausted) ||
                                          (w_loss && !r_auto_relock));
  assign w_irq_clr         = w_wr_irq ? writedata[1:0] : 2'b00;
  assign w_unused          = ^{writedata[15:4], read};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ASSERT_RST: if (r_rst_cnt == RST_LAST) w_state_nxt = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (w_lock)         w_state_nxt = ST_LOCKED;
        else if (w_timeout) w_state_nxt = w_retry_exhausted ? ST_FAULT : ST_ASSERT_RST;
      end
      ST_LOCKED:     if (w_loss) w_state_nxt = r_auto_relock ? ST_ASSERT_RST : ST_FAULT;
      default:       w_state_nxt = ST_FAULT;
    endcase
    if (w_force) w_state_nxt = ST_ASSERT_RST;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lk_meta      <= 1'b0;
      r_lk_s         <= 1'b0;
      r_state        <= ST_ASSERT_RST;
      r_rst_cnt      <= '0;
      r_filt         <= '0;
      r_tmo          <= '0;
      r_retry        <= 3'd0;
      r_pll_areset   <= 1'b1;
      r_resetrequest <= 1'b1;
    end else begin
      r_lk_meta      <= pll_locked;
      r_lk_s         <= r_lk_meta;
      r_state        <= w_state_nxt;
      r_pll_areset   <= (w_state_nxt == ST_ASSERT_RST) || (w_state_nxt == ST_FAULT);
      r_resetrequest <= (w_state_nxt != ST_LOCKED);

      // A forced reset while already in ASSERT_RST counts as a fresh entry.
      if ((r_state == ST_ASSERT_RST) && (w_state_nxt == ST_ASSERT_RST) && !w_force)
        r_rst_cnt <= r_rst_cnt + 1'b1;
      else
        r_rst_cnt <= '0;

      if ((r_state == ST_WAIT_LOCK) && (w_state_nxt == ST_WAIT_LOCK)) begin
        r_filt <= r_lk_s ? r_filt + 1'b1 : '0;
        r_tmo  <= r_tmo + 1'b1;
      end else begin
        r_filt <= '0;
        r_tmo  <= '0;
      end

      if (w_force || w_lock) r_retry <= 3'd0;
      else if (w_timeout)    r_retry <= w_retry_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_auto_relock <= 1'b1;
      r_irq_mask    <= 2'b00;
      r_loss_cnt    <= 16'h0000;
      r_irq_status  <= 2'b00;
      r_irq         <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_auto_relock <= writedata[1];
        r_irq_mask    <= writedata[3:2];
      end

      if (w_wr_loss)
        r_loss_cnt <= 16'h0000;
      else if (w_loss && (r_loss_cnt != 16'hFFFF))
        r_loss_cnt <= r_loss_cnt + 16'd1;

      r_irq_status <= (r_irq_status & ~w_irq_clr) | {w_set_fault, w_loss};
      r_irq        <= |(r_irq_status & r_irq_mask);
    end
  end

  always_comb begin
    readdata = 16'h0000;
    case (address)
      3'd0:    readdata = {8'h00, r_retry, r_state, r_lk_s,
                           (r_state == ST_FAULT), (r_state == ST_LOCKED)};
      3'd1:    readdata = {12'h000, r_irq_mask, r_auto_relock, 1'b0};
      3'd2:    readdata = r_loss_cnt;
      3'd3:    readdata = {14'h0000, r_irq_status};
      default: readdata = 16'h0000;
    endcase
  end

  assign pll_areset   = r_pll_areset;
  assign resetrequest = r_resetrequest;
  assign irq          = r_irq;

endmodule

// File: tb/tb_enet_pll_supervisor.sv
// tb/tb_enet_pll_supervisor.sv - directed self-checking bench for enet_pll_supervisor
module tb_enet_pll_supervisor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [15:0] writedata = 16'h0000;
  logic [15:0] readdata;
  logic        pll_locked = 1'b0;
  logic        pll_areset;
  logic        resetrequest;
  logic        irq;

  int checks = 0;
  int errors = 0;

  enet_pll_supervisor #(
    .RESET_CYCLES(4),
    .LOCK_FILTER (3),
    .LOCK_TIMEOUT(20),
    .MAX_RETRIES (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .address     (address),
    .chipselect  (chipselect),
    .read        (read),
    .write       (write),
    .writedata   (writedata),
    .readdata    (readdata),
    .pll_locked  (pll_locked),
    .pll_areset  (pll_areset),
    .resetrequest(resetrequest),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write = 1'b0; writedata = 16'h0000;
  endtask

  task automatic rd(input logic [2:0] a, output logic [15:0] d);
    chipselect = 1'b1; read = 1'b1; address = a;
    #1;
    d = readdata;
    chipselect = 1'b0; read = 1'b0;
  endtask

  // sel: 0 pll_areset, 1 resetrequest, 2 irq
  task automatic wait_for(input int sel, input logic level, input int bound, output int n);
    logic v;
    n = 0;
    for (int i = 0; i < bound; i++) begin
      tick();
      n++;
      v = (sel == 0) ? pll_areset : (sel == 1) ? resetrequest : irq;
      if (v === level) return;
    end
    checks++; errors++;
    $display("FAIL wait_sel%0d: level %0b not seen within %0d cycles", sel, level, bound);
    n = -1;
  endtask

  task automatic bring_up();
    int n;
    pll_locked = 1'b0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    wait_for(0, 1'b0, 50, n);
    pll_locked = 1'b1;
    wait_for(1, 1'b0, 50, n);
  endtask

  task automatic drop_lock_one_cycle();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
  endtask

  task automatic test_reset();
    logic [15:0] d;
    pll_locked = 1'b0;
    reset = 1'b1;
    tick(); tick();
    checks++; if (pll_areset !== 1'b1) begin errors++; $display("FAIL rst_areset: got %0b want 1", pll_areset); end
    checks++; if (resetrequest !== 1'b1) begin errors++; $display("FAIL rst_rr: got %0b want 1", resetrequest); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %0b want 0", irq); end
    rd(3'd0, d); checks++; if (d !== 16'h0000) begin errors++; $display("FAIL rst_status: got %h want 0000", d); end
    rd(3'd1, d); checks++; if (d !== 16'h0002) begin errors++; $display("FAIL rst_ctrl: got %h want 0002", d); end
    rd(3'd2, d); checks++; if (d !== 16'h0000) begin errors++; $display("FAIL rst_loss: got %h want 0000", d); end
    rd(3'd3, d); checks++; if (d !== 16'h0000) begin errors++; $display("FAIL rst_irqst: got %h want 0000", d); end
  endtask

  task automatic test_nominal();
    int n;
    logic [15:0] d;
    reset = 1'b0;
    wait_for(0, 1'b0, 50, n);
    checks++; if (n !== 4) begin errors++; $display("FAIL nom_areset_len: got %0d want 4", n); end
    pll_locked = 1'b1;
    wait_for(1, 1'b0, 50, n);
    checks++; if (n !== 5) begin errors++; $display("FAIL nom_lock_lat: got %0d want 5", n); end
    rd(3'd0, d); checks++; if (d !== 16'h0015) begin errors++; $display("FAIL nom_status: got %h want 0015", d); end
    checks++; if (pll_areset !== 1'b0) begin errors++; $display("FAIL nom_areset: got %0b want 0", pll_areset); end
  endtask

  task automatic test_glitch();
    int n;
    logic [15:0] d;
    logic [5:0] pat;
    pat = 6'b111011;  // applied LSB first: 1,1,0,1,1,1
    pll_locked = 1'b0;
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    wait_for(0, 1'b0, 50, n);
    n = 0;
    for (int k = 0; k < 6; k++) begin
      pll_locked = pat[k];
      tick();
      n++;
      if (resetrequest === 1'b0) break;
    end
    if (resetrequest !== 1'b0) begin
      int m;
      wait_for(1, 1'b0, 50, m);
      n = n + m;
    end
    checks++; if (n !== 8) begin errors++; $display("FAIL glitch_lock_lat: got %0d want 8", n); end
    rd(3'd0, d); checks++; if (d !== 16'h0015) begin errors++; $display("FAIL glitch_status: got %h want 0015", d); end
  endtask

  task automatic test_timeout();
    int n;
    logic [15:0] d;
    pll_locked = 1'b0;
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    wait_for(0, 1'b0, 50, n);
    checks++; if (n !== 4) begin errors++; $display("FAIL to_rst1: got %0d want 4", n); end
    wait_for(0, 1'b1, 50, n);
    checks++; if (n !== 20) begin errors++; $display("FAIL to_wait1: got %0d want 20", n); end
    wait_for(0, 1'b0, 50, n);
    checks++; if (n !== 4) begin errors++; $display("FAIL to_rst2: got %0d want 4", n); end
    wait_for(0, 1'b1, 50, n);
    checks++; if (n !== 20) begin errors++; $display("FAIL to_wait2: got %0d want 20", n); end
    rd(3'd0, d); checks++; if (d !== 16'h005A) begin errors++; $display("FAIL to_status: got %h want 005a", d); end
    rd(3'd3, d); checks++; if (d !== 16'h0002) begin errors++; $display("FAIL to_irqst: got %h want 0002", d); end
    for (int i = 0; i < 30; i++) tick();
    rd(3'd0, d); checks++; if (d !== 16'h005A) begin errors++; $display("FAIL to_sticky: got %h want 005a", d); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL to_irq_masked: got %0b want 0", irq); end
    wr(3'd1, 16'h0008);
    tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL to_irq_unmasked: got %0b want 1", irq); end
  endtask

  task automatic test_loss_relock();
    int n;
    logic [15:0] d;
    bring_up();
    drop_lock_one_cycle();
    tick(); tick();
    rd(3'd0, d); checks++; if (d !== 16'h0004) begin errors++; $display("FAIL lr_status: got %h want 0004", d); end
    rd(3'd2, d); checks++; if (d !== 16'h0001) begin errors++; $display("FAIL lr_loss: got %h want 0001", d); end
    rd(3'd3, d); checks++; if (d !== 16'h0001) begin errors++; $display("FAIL lr_irqst: got %h want 0001", d); end
    wait_for(1, 1'b0, 50, n);
    checks++; if (n !== 7) begin errors++; $display("FAIL lr_relock: got %0d want 7", n); end
    wr(3'd3, 16'h0001);
    rd(3'd3, d); checks++; if (d !== 16'h0000) begin errors++; $display("FAIL lr_w1c: got %h want 0000", d); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL lr_irq: got %0b want 0", irq); end
  endtask

  task automatic test_no_relock();
    int n;
    logic [15:0] d;
    bring_up();
    wr(3'd1, 16'h0000);
    drop_lock_one_cycle();
    tick(); tick();
    rd(3'd0, d); checks++; if (d !== 16'h001E) begin errors++; $display("FAIL nr_status: got %h want 001e", d); end
    rd(3'd3, d); checks++; if (d !== 16'h0003) begin errors++; $display("FAIL nr_irqst: got %h want 0003", d); end
    wr(3'd1, 16'h0001);
    rd(3'd0, d); checks++; if (d !== 16'h0004) begin errors++; $display("FAIL nr_force: got %h want 0004", d); end
    wait_for(1, 1'b0, 50, n);
    checks++; if (n !== 7) begin errors++; $display("FAIL nr_relock: got %0d want 7", n); end
  endtask

  task automatic test_force_vs_timeout();
    int n;
    logic [15:0] d;
    pll_locked = 1'b0;
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    wait_for(0, 1'b0, 50, n);
    wait_for(0, 1'b1, 50, n);
    wait_for(0, 1'b0, 50, n);
    for (int i = 0; i < 19; i++) tick();
    rd(3'd0, d); checks++; if (d !== 16'h0028) begin errors++; $display("FAIL fv_pre: got %h want 0028", d); end
    wr(3'd1, 16'h0003);
    rd(3'd0, d); checks++; if (d !== 16'h0000) begin errors++; $display("FAIL fv_status: got %h want 0000", d); end
    rd(3'd3, d); checks++; if (d !== 16'h0000) begin errors++; $display("FAIL fv_irqst: got %h want 0000", d); end
  endtask

  task automatic test_loss_cnt_corners();
    int n;
    logic [15:0] d;
    bring_up();
    force dut.r_loss_cnt = 16'hFFFF;
    tick();
    release dut.r_loss_cnt;
    drop_lock_one_cycle();
    tick(); tick();
    rd(3'd2, d); checks++; if (d !== 16'hFFFF) begin errors++; $display("FAIL sat_loss: got %h want ffff", d); end
    wait_for(1, 1'b0, 50, n);
    drop_lock_one_cycle();
    tick();
    wr(3'd2, 16'h1234);
    rd(3'd2, d); checks++; if (d !== 16'h0000) begin errors++; $display("FAIL clr_vs_loss: got %h want 0000", d); end
    rd(3'd0, d); checks++; if (d !== 16'h0004) begin errors++; $display("FAIL clr_vs_loss_state: got %h want 0004", d); end
  endtask

  task automatic test_reset_mid();
    int n;
    logic [15:0] d;
    bring_up();
    drop_lock_one_cycle();
    tick(); tick();
    wr(3'd1, 16'h000E);
    wait_for(0, 1'b0, 50, n);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL mid_irq_pre: got %0b want 1", irq); end
    reset = 1'b1;
    tick();
    checks++; if (pll_areset !== 1'b1) begin errors++; $display("FAIL mid_areset: got %0b want 1", pll_areset); end
    checks++; if (resetrequest !== 1'b1) begin errors++; $display("FAIL mid_rr: got %0b want 1", resetrequest); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mid_irq: got %0b want 0", irq); end
    rd(3'd0, d); checks++; if (d !== 16'h0000) begin errors++; $display("FAIL mid_status: got %h want 0000", d); end
    rd(3'd1, d); checks++; if (d !== 16'h0002) begin errors++; $display("FAIL mid_ctrl: got %h want 0002", d); end
    rd(3'd2, d); checks++; if (d !== 16'h0000) begin errors++; $display("FAIL mid_loss: got %h want 0000", d); end
    rd(3'd3, d); checks++; if (d !== 16'h0000) begin errors++; $display("FAIL mid_irqst: got %h want 0000", d); end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_glitch();
    test_timeout();
    test_loss_relock();
    test_no_relock();
    test_force_vs_timeout();
    test_loss_cnt_corners();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
